mesh_shift_engine: RTL

Parametrised ROWS x COLS mesh of DATA_W-bit PE data registers with a nearest-neighbour shift engine. It is the successor of the fixed square SIZE x SIZE, 8-bit, torus-only neighbour links. One command shifts the whole mesh east, west, south or north by a programmable number of hops, one hop per cycle. Edge handling is selectable: torus wrap or zero-fill. It sits between the array controller and the PE blocks, with a load port for initialisation and a read port for result readback.

---
 rtl/mesh_shift_engine.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mesh_shift_engine.sv
// mesh_shift_engine
//   ROWS x COLS mesh of DATA_W-bit PE data registers with a nearest-neighbour
//   shift engine. One command moves every PE word east, west, south or north
//   by a programmable number of hops, one hop per clock. At the mesh boundary
//   the incoming word either wraps around (torus) or is zero.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   ld_en      write ld_data into PE ld_addr (IDLE only)
//   ld_addr    PE index, i = r*COLS + c
//   ld_data    load word
//   start      command strobe (IDLE only)
//   dir        0=east, 1=west, 2=south, 3=north
//   hops       number of single-hop shifts
//   edge_mode  0=torus wrap, 1=zero-fill
//   busy       command in progress (SHIFT or FIN)
//   done       one-cycle completion pulse (FIN)
//   rd_addr    readback PE index
//   rd_data    combinational word of PE rd_addr (0 when out of range)
//   mesh_flat  all PE words, PE i at bits [i*DATA_W +: DATA_W]
module mesh_shift_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 7,
  parameter int AW     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_en,
  input  logic [AW-1:0]               ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic                        start,
  input  logic [1:0]                  dir,
  input  logic [CNT_W-1:0]            hops,
  input  logic                        edge_mode,
  output logic                        busy,
  output logic                        done,
  input  logic [AW-1:0]               rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [ROWS*COLS*DATA_W-1:0] mesh_flat
);

  localparam int NPE = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  pe_q   [NPE];
  logic [DATA_W-1:0]  pe_hop [NPE];
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         dir_q;
  logic               edge_q;

  // State register; reset aborts any running command without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A zero-hop command goes straight to FIN so done still
  // pulses once; the hop that takes the counter from 1 to 0 is the last one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (hops == '0) ? FIN : SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state, so done is glitch-free.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIN);
  end

  // One-hop image of the whole mesh for the latched direction. Edge PEs take
  // either the word from the opposite edge (torus) or zero.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        pe_hop[r*COLS+c] = '0;
        case (dir_q)
          2'd0: begin
            if (c > 0)        pe_hop[r*COLS+c] = pe_q[r*COLS+c-1];
            else if (!edge_q) pe_hop[r*COLS+c] = pe_q[r*COLS+COLS-1];
          end
          2'd1: begin
            if (c < COLS-1)   pe_hop[r*COLS+c] = pe_q[r*COLS+c+1];
            else if (!edge_q) pe_hop[r*COLS+c] = pe_q[r*COLS];
          end
          2'd2: begin
            if (r > 0)        pe_hop[r*COLS+c] = pe_q[(r-1)*COLS+c];
            else if (!edge_q) pe_hop[r*COLS+c] = pe_q[(ROWS-1)*COLS+c];
          end
          default: begin
            if (r < ROWS-1)   pe_hop[r*COLS+c] = pe_q[(r+1)*COLS+c];
            else if (!edge_q) pe_hop[r*COLS+c] = pe_q[c];
          end
        endcase
      end
    end
  end

  // Datapath: loads and command latching only in IDLE (a load and a start in
  // the same cycle both land, so the first hop sees the loaded word); hops
  // only in SHIFT. Out-of-range load addresses match no PE and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPE; i++) pe_q[i] <= '0;
      cnt_q  <= '0;
      dir_q  <= '0;
      edge_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          for (int i = 0; i < NPE; i++) begin
            if (ld_en && (ld_addr == AW'(i))) pe_q[i] <= ld_data;
          end
          if (start) begin
            dir_q  <= dir;
            edge_q <= edge_mode;
            cnt_q  <= hops;
          end
        end
        SHIFT: begin
          for (int i = 0; i < NPE; i++) pe_q[i] <= pe_hop[i];
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Readback and flat view; an address past the last PE matches nothing.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPE; i++) begin
      if (rd_addr == AW'(i)) rd_data = pe_q[i];
    end
  end

  always_comb begin
    mesh_flat = '0;
    for (int i = 0; i < NPE; i++) mesh_flat[i*DATA_W +: DATA_W] = pe_q[i];
  end

endmodule
